// File: rtl/btn_toggle_gen.sv
// Button synchronizer, debouncer and toggle-pulse generator for the T flip-flop.
// Optional auto-repeat while held: define BTN_AUTO_REPEAT_EN.
module btn_toggle_gen #(
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  input  logic       enable,
  output logic       t_out,
  output logic       btn_state,
  output logic [7:0] press_count
);

  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } state_t;

  state_t        state;
  logic          s1;
  logic          btn_s;
  logic [DW-1:0] db_cnt;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_phase;
  logic [RW-1:0] rpt_lim;

  assign rpt_lim = rpt_phase ? PER_LAST : DLY_LAST;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= 1'b0;
      btn_s       <= 1'b0;
      state       <= IDLE;
      db_cnt      <= '0;
      t_out       <= 1'b0;
      btn_state   <= 1'b0;
      press_count <= 8'd0;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_cnt     <= '0;
      rpt_phase   <= 1'b0;
`endif
    end else begin
      s1    <= btn_in;
      btn_s <= s1;
      t_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (btn_s) begin
            state  <= PRESS_CHK;
            db_cnt <= '0;
          end
        end
        PRESS_CHK: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state       <= HELD;
            btn_state   <= 1'b1;
            t_out       <= enable;
            press_count <= press_count + 8'(enable);
`ifdef BTN_AUTO_REPEAT_EN
            rpt_cnt     <= '0;
            rpt_phase   <= 1'b0;
`endif
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state  <= RELEASE_CHK;
            db_cnt <= '0;
          end
`ifdef BTN_AUTO_REPEAT_EN
          // repeat timing pauses while a release is being qualified
          else if (rpt_cnt == rpt_lim) begin
            t_out       <= enable;
            press_count <= press_count + 8'(enable);
            rpt_phase   <= 1'b1;
            rpt_cnt     <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
`endif
        end
        RELEASE_CHK: begin
          if (btn_s) begin
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            state     <= IDLE;
            btn_state <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_toggle_gen.sv
// Scoreboard bench for btn_toggle_gen: run-length debounce reference model,
// directed scenarios, press_count wrap and randomized bouncy stimulus.
module tb_btn_toggle_gen;

  localparam int DB = 16;
  localparam int RD = 64;
  localparam int RP = 16;
`ifdef BTN_AUTO_REPEAT_EN
  localparam int HOLD200_PULSES = 9;
`else
  localparam int HOLD200_PULSES = 1;
`endif

  logic       clk;
  logic       reset;
  logic       btn_in;
  logic       enable;
  logic       t_out;
  logic       btn_state;
  logic [7:0] press_count;

  btn_toggle_gen #(
    .DB_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .enable(enable),
    .t_out(t_out),
    .btn_state(btn_state),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       t;
    logic       st;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails = 0;
  int   pulses = 0;
  time  last_pulse_t = 0;
  time  e0 = 0;

  // reference: accepted level changes after DB+1 consecutive
  // disagreeing synchronized samples
  logic       m_s1, m_s2, m_acc, m_t, m_phase;
  int         m_run, m_rpt;
  logic [7:0] m_cnt;

  function automatic void emit(input logic en);
    m_t = en;
    if (en) m_cnt = m_cnt + 8'd1;
  endfunction

  function automatic void model_step(input logic b, input logic en,
                                     input logic rst);
    logic bs;
`ifdef BTN_AUTO_REPEAT_EN
    logic steady;
    steady = m_acc && (m_run == 0);
`endif
    bs = m_s2;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_acc = 0; m_t = 0; m_phase = 0;
      m_run = 0; m_rpt = 0; m_cnt = 0;
    end else begin
      m_t = 0;
      if (bs != m_acc) begin
        m_run++;
        if (m_run == DB + 1) begin
          m_acc = bs;
          m_run = 0;
          if (bs) begin
            emit(en);
            m_rpt = 0;
            m_phase = 0;
          end
        end
      end else begin
        m_run = 0;
`ifdef BTN_AUTO_REPEAT_EN
        if (steady) begin
          m_rpt++;
          if (m_rpt == (m_phase ? RP : RD)) begin
            emit(en);
            m_phase = 1;
            m_rpt = 0;
          end
        end
`endif
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
    q.push_back(exp_t'{m_t, m_acc, m_cnt});
  endfunction

  function automatic void check(input string name, input int act,
                                input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
               $time);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (t_out === 1'b1) begin
        pulses++;
        last_pulse_t = $time;
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        check("t_out", int'(t_out), int'(e.t));
        check("btn_state", int'(btn_state), int'(e.st));
        check("press_count", int'(press_count), int'(e.cnt));
      end
    end
  end

  task automatic drive(input logic b, input logic en, input logic rst);
    @(negedge clk);
    btn_in = b;
    enable = en;
    reset  = rst;
    model_step(b, en, rst);
  endtask

  task automatic hold(input logic b, input int n, input logic en);
    for (int i = 0; i < n; i++) drive(b, en, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    hold(1'b0, 3, 1'b1);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  function automatic int pulse_edge();
    return int'((last_pulse_t - 1 - e0) / 10);
  endfunction

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int p0;
    btn_in = 0;
    enable = 0;
    reset  = 1;

    // clean press
    do_reset();
    p0 = pulses;
    drive(1'b1, 1'b1, 1'b0);
    e0 = $time + 5;
    hold(1'b1, 39, 1'b1);
    hold(1'b0, 30, 1'b1);
    settle();
    check("clean_pulses", pulses - p0, 1);
    check("clean_edge", pulse_edge(), DB + 2);
    check("clean_count", int'(press_count), 1);

    // glitch
    do_reset();
    p0 = pulses;
    hold(1'b1, 10, 1'b1);
    hold(1'b0, 30, 1'b1);
    settle();
    check("glitch_pulses", pulses - p0, 0);
    check("glitch_count", int'(press_count), 0);

    // bounce then hold
    do_reset();
    p0 = pulses;
    hold(1'b1, 3, 1'b1);
    hold(1'b0, 3, 1'b1);
    hold(1'b1, 3, 1'b1);
    hold(1'b0, 3, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    e0 = $time + 5;
    hold(1'b1, 39, 1'b1);
    hold(1'b0, 30, 1'b1);
    settle();
    check("bounce_pulses", pulses - p0, 1);
    check("bounce_edge", pulse_edge(), DB + 2);
    check("bounce_count", int'(press_count), 1);

    // enable low
    do_reset();
    p0 = pulses;
    hold(1'b1, 40, 1'b0);
    settle();
    check("noen_state", int'(btn_state), 1);
    hold(1'b0, 30, 1'b0);
    settle();
    check("noen_pulses", pulses - p0, 0);
    check("noen_count", int'(press_count), 0);

    // reset during press qualification
    do_reset();
    p0 = pulses;
    hold(1'b1, 12, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    settle();
    check("rst_state", int'(btn_state), 0);
    check("rst_count", int'(press_count), 0);
    drive(1'b1, 1'b1, 1'b0);
    e0 = $time + 5;
    hold(1'b1, 39, 1'b1);
    hold(1'b0, 30, 1'b1);
    settle();
    check("rst_pulses", pulses - p0, 1);
    check("rst_edge", pulse_edge(), DB + 2);

    // long hold
    do_reset();
    p0 = pulses;
    hold(1'b1, 200, 1'b1);
    hold(1'b0, 40, 1'b1);
    settle();
    check("hold_pulses", pulses - p0, HOLD200_PULSES);
    check("hold_count", int'(press_count), HOLD200_PULSES);

    // press_count wrap
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 260; i++) begin
      hold(1'b1, 20, 1'b1);
      hold(1'b0, 20, 1'b1);
    end
    settle();
    check("wrap_pulses", pulses - p0, 260);
    check("wrap_count", int'(press_count), 4);

    // randomized bouncy segments
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic lvl, en;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 30);
      if ($urandom_range(0, 49) == 0) drive(lvl, en, 1'b1);
      hold(lvl, len, en);
    end
    hold(1'b0, 40, 1'b1);
    settle();
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
